// File: rtl/csr_pkg.sv
// Shared defaults and FSM state type for the two-requester CSR bus arbiter.
package csr_pkg;

  localparam int unsigned DefAddrW    = 8;
  localparam int unsigned DefDataW    = 16;
  localparam logic [15:0] DefToutData = 16'hDEAD;

  typedef enum logic [0:0] {
    StIdle,
    StRdWait
  } csr_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a one-bit "served last" pointer.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  // last_q = 1 means m1 was served last, so m0 wins the next tie.
  logic last_q, last_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
    idx_o  = gnt_o[1];
    last_d = last_q;
    if (en_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/csr_arb.sv
// Arbitrates two requesters onto one registered CSR bus; reads wait for a
// response or time out and return TOUT_DATA with a tout_err pulse.
module csr_arb
  import csr_pkg::*;
#(
  parameter int unsigned            CSR_ADDR_W = DefAddrW,
  parameter int unsigned            CSR_DATA_W = DefDataW,
  parameter int unsigned            RD_TIMEOUT = 255,
  parameter logic [CSR_DATA_W-1:0]  TOUT_DATA  = CSR_DATA_W'(DefToutData)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CSR_ADDR_W-1:0] m0_addr,
  input  logic                  m0_wen,
  input  logic [CSR_DATA_W-1:0] m0_wdata,
  input  logic                  m0_ren,
  output logic                  m0_ack,
  output logic                  m0_rvalid,
  output logic [CSR_DATA_W-1:0] m0_rdata,
  input  logic [CSR_ADDR_W-1:0] m1_addr,
  input  logic                  m1_wen,
  input  logic [CSR_DATA_W-1:0] m1_wdata,
  input  logic                  m1_ren,
  output logic                  m1_ack,
  output logic                  m1_rvalid,
  output logic [CSR_DATA_W-1:0] m1_rdata,
  output logic                  tout_err,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic                  csr_wen,
  output logic [CSR_DATA_W-1:0] csr_wdata,
  output logic                  csr_ren,
  input  logic                  csr_rvalid,
  input  logic [CSR_DATA_W-1:0] csr_rdata
);

  localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);

  csr_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CSR_ADDR_W-1:0] csr_addr_q, csr_addr_d;
  logic [CSR_DATA_W-1:0] csr_wdata_q, csr_wdata_d;
  logic                  csr_wen_q, csr_wen_d;
  logic                  csr_ren_q, csr_ren_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [CSR_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                  tout_err_q, tout_err_d;

  logic [1:0]            req, gnt;
  logic                  gnt_idx, arb_en, issue;
  logic [CSR_ADDR_W-1:0] sel_addr;
  logic [CSR_DATA_W-1:0] sel_wdata;
  logic                  sel_wen;

  assign req    = {m1_wen | m1_ren, m0_wen | m0_ren};
  assign arb_en = (state_q == StIdle) && rst_n;

  rr_arb2 u_rr_arb2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req),
    .en_i   (arb_en),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  assign m0_ack    = arb_en & gnt[0];
  assign m1_ack    = arb_en & gnt[1];
  assign issue     = m0_ack | m1_ack;
  assign sel_addr  = gnt_idx ? m1_addr : m0_addr;
  assign sel_wdata = gnt_idx ? m1_wdata : m0_wdata;
  assign sel_wen   = gnt_idx ? m1_wen : m0_wen;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    csr_wen_d   = 1'b0;
    csr_ren_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    tout_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          csr_addr_d = sel_addr;
          // A simultaneous read is dropped in favour of the write.
          if (sel_wen) begin
            csr_wen_d   = 1'b1;
            csr_wdata_d = sel_wdata;
          end else begin
            csr_ren_d = 1'b1;
            owner_d   = gnt_idx;
            cnt_d     = '0;
            state_d   = StRdWait;
          end
        end
      end
      StRdWait: begin
        // Real data takes priority over a timeout in the same cycle.
        if (csr_rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = csr_rdata;
          state_d     = StIdle;
        end else if (cnt_q == CntW'(RD_TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = TOUT_DATA;
          tout_err_d  = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_wen_q   <= 1'b0;
      csr_ren_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tout_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      csr_wen_q   <= csr_wen_d;
      csr_ren_q   <= csr_ren_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tout_err_q  <= tout_err_d;
    end
  end

  assign csr_addr  = csr_addr_q;
  assign csr_wdata = csr_wdata_q;
  assign csr_wen   = csr_wen_q;
  assign csr_ren   = csr_ren_q;
  assign tout_err  = tout_err_q;
  assign m0_rvalid = rsp_valid_q & ~owner_q;
  assign m1_rvalid = rsp_valid_q & owner_q;
  assign m0_rdata  = m0_rvalid ? rsp_data_q : '0;
  assign m1_rdata  = m1_rvalid ? rsp_data_q : '0;

endmodule

// File: tb/tb_csr_arb.sv
// Directed self-checking bench for csr_arb with hand-computed expectations.
module tb_csr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  m0_addr, m1_addr, csr_addr;
  logic        m0_wen, m0_ren, m1_wen, m1_ren;
  logic [15:0] m0_wdata, m1_wdata, csr_wdata;
  logic        m0_ack, m1_ack, m0_rvalid, m1_rvalid, tout_err;
  logic [15:0] m0_rdata, m1_rdata, csr_rdata;
  logic        csr_wen, csr_ren, csr_rvalid;

  int n_chk  = 0;
  int n_fail = 0;

  csr_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_addr    (m0_addr),
    .m0_wen     (m0_wen),
    .m0_wdata   (m0_wdata),
    .m0_ren     (m0_ren),
    .m0_ack     (m0_ack),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_addr    (m1_addr),
    .m1_wen     (m1_wen),
    .m1_wdata   (m1_wdata),
    .m1_ren     (m1_ren),
    .m1_ack     (m1_ack),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .tout_err   (tout_err),
    .csr_addr   (csr_addr),
    .csr_wen    (csr_wen),
    .csr_wdata  (csr_wdata),
    .csr_ren    (csr_ren),
    .csr_rvalid (csr_rvalid),
    .csr_rdata  (csr_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_addr = '0; m0_wen = 0; m0_wdata = '0; m0_ren = 0;
    m1_addr = '0; m1_wen = 0; m1_wdata = '0; m1_ren = 0;
    csr_rvalid = 0; csr_rdata = '0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    clear_inputs();
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    m0_wen = 1; m0_addr = 8'h77; m0_wdata = 16'h9999;
    step();
    #1;
    n_chk++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack0: got %b want 0", m0_ack); end
    step();
    n_chk++; if (csr_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b want 0", csr_wen); end
    n_chk++; if (csr_ren !== 1'b0) begin n_fail++; $display("FAIL rst_ren: got %b want 0", csr_ren); end
    n_chk++; if (csr_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h want 00", csr_addr); end
    n_chk++; if (csr_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", csr_wdata); end
    n_chk++; if ({m0_rvalid, m1_rvalid, tout_err} !== 3'b000) begin
      n_fail++; $display("FAIL rst_rsp: got %b want 000", {m0_rvalid, m1_rvalid, tout_err});
    end
    m0_wen = 0;
    rst_n = 1;
  endtask

  task automatic test_single_write();
    m0_addr = 8'h10; m0_wdata = 16'h1234; m0_wen = 1;
    #1;
    n_chk++; if ({m1_ack, m0_ack} !== 2'b01) begin n_fail++; $display("FAIL wr_ack: got %b want 01", {m1_ack, m0_ack}); end
    step();
    m0_wen = 0; m0_addr = 8'hFF; m0_wdata = 16'hFFFF;
    n_chk++; if (csr_wen !== 1'b1) begin n_fail++; $display("FAIL wr_wen: got %b want 1", csr_wen); end
    n_chk++; if (csr_ren !== 1'b0) begin n_fail++; $display("FAIL wr_ren: got %b want 0", csr_ren); end
    n_chk++; if (csr_addr !== 8'h10) begin n_fail++; $display("FAIL wr_addr: got %h want 10", csr_addr); end
    n_chk++; if (csr_wdata !== 16'h1234) begin n_fail++; $display("FAIL wr_wdata: got %h want 1234", csr_wdata); end
    step();
    n_chk++; if (csr_wen !== 1'b0) begin n_fail++; $display("FAIL wr_pulse: got %b want 0", csr_wen); end
    n_chk++; if ({csr_addr, csr_wdata} !== {8'h10, 16'h1234}) begin
      n_fail++; $display("FAIL wr_hold: got %h/%h want 10/1234", csr_addr, csr_wdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_addr [3];
    exp_addr[0] = 8'h20; exp_addr[1] = 8'h30; exp_addr[2] = 8'h20;
    apply_reset();
    m0_addr = 8'h20; m0_wdata = 16'h00A0; m0_wen = 1;
    m1_addr = 8'h30; m1_wdata = 16'h00B0; m1_wen = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if ({m1_ack, m0_ack} !== ((i == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL b2b_ack%0d: got %b", i, {m1_ack, m0_ack});
      end
      step();
      if (i == 2) begin m0_wen = 0; m1_wen = 0; end
      n_chk++; if ({csr_wen, csr_addr} !== {1'b1, exp_addr[i]}) begin
        n_fail++; $display("FAIL b2b_bus%0d: got %b/%h want 1/%h", i, csr_wen, csr_addr, exp_addr[i]);
      end
    end
    step();
  endtask

  task automatic test_read();
    m1_addr = 8'h22; m1_ren = 1;
    #1;
    n_chk++; if ({m1_ack, m0_ack} !== 2'b10) begin n_fail++; $display("FAIL rd_ack: got %b want 10", {m1_ack, m0_ack}); end
    step();
    m1_ren = 0;
    m0_addr = 8'h40; m0_wdata = 16'h0055; m0_wen = 1;
    n_chk++; if ({csr_ren, csr_wen, csr_addr} !== {2'b10, 8'h22}) begin
      n_fail++; $display("FAIL rd_bus: got %b%b/%h want 10/22", csr_ren, csr_wen, csr_addr);
    end
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_chk++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL rd_wait_ack%0d: got %b want 0", c, m0_ack); end
      step();
    end
    csr_rvalid = 1; csr_rdata = 16'hBEEF;
    #1;
    n_chk++; if ({m0_ack, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rd_early: got %b want 00", {m0_ack, m1_rvalid}); end
    step();
    csr_rvalid = 0; csr_rdata = 16'h0;
    n_chk++; if ({m1_rvalid, m1_rdata} !== {1'b1, 16'hBEEF}) begin
      n_fail++; $display("FAIL rd_data: got %b/%h want 1/beef", m1_rvalid, m1_rdata);
    end
    n_chk++; if ({m0_rvalid, m0_rdata} !== 17'h0) begin
      n_fail++; $display("FAIL rd_other: got %b/%h want 0/0", m0_rvalid, m0_rdata);
    end
    n_chk++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL rd_idle_ack: got %b want 1", m0_ack); end
    step();
    m0_wen = 0;
    n_chk++; if ({csr_wen, csr_addr, m1_rvalid, m1_rdata} !== {1'b1, 8'h40, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL rd_after: got %b/%h/%b/%h want 1/40/0/0", csr_wen, csr_addr, m1_rvalid, m1_rdata);
    end
  endtask

  task automatic test_timeout();
    logic early = 0;
    m0_addr = 8'h33; m0_ren = 1;
    #1;
    n_chk++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL to_ack: got %b want 1", m0_ack); end
    for (int i = 1; i <= 255; i++) begin
      step();
      if (i == 1) m0_ren = 0;
      if (m0_rvalid || m1_rvalid || tout_err || m1_ack) early = 1;
      if (i == 1) m1_wen = 0;
    end
    n_chk++; if (early !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", early); end
    step();
    n_chk++; if ({m0_rvalid, m0_rdata, tout_err, m1_rvalid} !== {1'b1, 16'hDEAD, 2'b10}) begin
      n_fail++; $display("FAIL to_rsp: got %b/%h/%b/%b want 1/dead/1/0", m0_rvalid, m0_rdata, tout_err, m1_rvalid);
    end
    m1_addr = 8'h50; m1_wdata = 16'h0001; m1_wen = 1;
    #1;
    n_chk++; if (m1_ack !== 1'b1) begin n_fail++; $display("FAIL to_idle_ack: got %b want 1", m1_ack); end
    step();
    m1_wen = 0;
    n_chk++; if ({tout_err, m0_rvalid, csr_wen} !== 3'b001) begin
      n_fail++; $display("FAIL to_pulse: got %b want 001", {tout_err, m0_rvalid, csr_wen});
    end
  endtask

  task automatic test_coincident();
    logic early = 0;
    m1_addr = 8'h66; m1_ren = 1;
    #1;
    n_chk++; if (m1_ack !== 1'b1) begin n_fail++; $display("FAIL co_ack: got %b want 1", m1_ack); end
    for (int i = 1; i <= 255; i++) begin
      step();
      if (i == 1) m1_ren = 0;
      if (m0_rvalid || m1_rvalid || tout_err) early = 1;
      if (i == 255) begin csr_rvalid = 1; csr_rdata = 16'h1111; end
    end
    n_chk++; if (early !== 1'b0) begin n_fail++; $display("FAIL co_early: got %b want 0", early); end
    step();
    csr_rvalid = 0; csr_rdata = 16'h0;
    n_chk++; if ({m1_rvalid, m1_rdata, tout_err, m0_rvalid} !== {1'b1, 16'h1111, 2'b00}) begin
      n_fail++; $display("FAIL co_rsp: got %b/%h/%b/%b want 1/1111/0/0", m1_rvalid, m1_rdata, tout_err, m0_rvalid);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    m0_addr = 8'h44; m0_ren = 1;
    #1;
    n_chk++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL rw_ack: got %b want 1", m0_ack); end
    step();
    m0_ren = 0;
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    csr_rvalid = 1; csr_rdata = 16'h7777;
    step();
    csr_rvalid = 0; csr_rdata = 16'h0;
    n_chk++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL rw_rvalid: got %b want 00", {m0_rvalid, m1_rvalid});
    end
    m0_addr = 8'h01; m0_wen = 1; m1_addr = 8'h02; m1_wen = 1;
    #1;
    n_chk++; if ({m1_ack, m0_ack} !== 2'b01) begin n_fail++; $display("FAIL rw_tie: got %b want 01", {m1_ack, m0_ack}); end
    step();
    m0_wen = 0; m1_wen = 0;
    n_chk++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL rw_late: got %b want 00", {m0_rvalid, m1_rvalid});
    end
    step();
  endtask

  task automatic test_wen_ren();
    m0_addr = 8'h05; m0_wdata = 16'h0F0F; m0_wen = 1; m0_ren = 1;
    #1;
    n_chk++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL wr_rd_ack: got %b want 1", m0_ack); end
    step();
    m0_wen = 0; m0_ren = 0;
    n_chk++; if ({csr_wen, csr_ren, csr_addr, csr_wdata} !== {2'b10, 8'h05, 16'h0F0F}) begin
      n_fail++; $display("FAIL wr_rd_bus: got %b%b/%h/%h want 10/05/0f0f", csr_wen, csr_ren, csr_addr, csr_wdata);
    end
    csr_rvalid = 1; csr_rdata = 16'h4242;
    m1_addr = 8'h09; m1_wen = 1;
    #1;
    n_chk++; if ({m1_ack, m0_ack} !== 2'b10) begin n_fail++; $display("FAIL wr_rd_idle: got %b want 10", {m1_ack, m0_ack}); end
    step();
    csr_rvalid = 0; m1_wen = 0;
    n_chk++; if ({csr_ren, m0_rvalid, m1_rvalid} !== 3'b000) begin
      n_fail++; $display("FAIL wr_rd_ign: got %b want 000", {csr_ren, m0_rvalid, m1_rvalid});
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read();
    test_timeout();
    test_coincident();
    test_reset_in_wait();
    test_wen_ren();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
